// File: rtl/cms_pkg.sv
// Shared constants and helpers for the trace stream receiver.
package cms_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 64;
    localparam int CNT_WIDTH  = 32;

    // Control register map
    localparam logic [ADDR_WIDTH-1:0] CMS_RX_ADDR_INTERVAL = 8'h00;
    localparam logic [ADDR_WIDTH-1:0] CMS_RX_ADDR_CLEAR    = 8'h01;
    localparam logic [ADDR_WIDTH-1:0] CMS_RX_ADDR_BEATS    = 8'h02;
    localparam logic [ADDR_WIDTH-1:0] CMS_RX_ADDR_FRAMES   = 8'h03;
    localparam logic [ADDR_WIDTH-1:0] CMS_RX_ADDR_ERRS     = 8'h04;
    localparam logic [ADDR_WIDTH-1:0] CMS_RX_ADDR_OCC      = 8'h05;

    // Field offsets inside a tdata beat: {pc, instr}
    localparam int INSTR_LSB = 0;
    localparam int PC_LSB    = 32;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        if (value == 32'hFFFF_FFFF) begin
            sat_inc = value;
        end else begin
            sat_inc = value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/cms_fwft_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on rdata
// whenever empty is low, with no read latency.
module cms_fwft_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] occ_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_s    = (occ_r == OCC_W'(DEPTH));
    assign empty_s   = (occ_r == {OCC_W{1'b0}});
    assign do_push_s = push & ~full_s;
    assign do_pop_s  = pop & ~empty_s;

    assign full      = full_s;
    assign empty     = empty_s;
    assign occupancy = occ_r;
    assign rdata     = mem_r[rd_ptr_r];

    // Storage array; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers (wrap naturally at the power-of-two depth) and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1'b1);
                2'b01:   occ_r <= occ_r - OCC_W'(1'b1);
                default: occ_r <= occ_r;
            endcase
        end
    end

endmodule

// File: rtl/cms_stream_receiver.sv
// AXI-Stream sink for monitoring trace beats: buffers beats, unpacks
// {pc, instr}, checks tlast framing and keeps saturating statistics.
module cms_stream_receiver
    import cms_pkg::*;
#(
    parameter int XLEN                                = 64,
    parameter int AXI_DATA_WIDTH                      = XLEN + 32,
    parameter int FIFO_DEPTH                          = 4,
    parameter int DEFAULT_INTERVAL                    = 100,
    parameter int CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      S_AXIS_tvalid,
    output logic                      S_AXIS_tready,
    input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                      S_AXIS_tlast,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [31:0]               out_instr,
    output logic                      out_last,
    input  logic [ADDR_WIDTH-1:0]     ctrl_addr,
    input  logic [DATA_WIDTH-1:0]     ctrl_wdata,
    input  logic                      ctrl_write_enable,
    output logic [DATA_WIDTH-1:0]     ctrl_rdata
);

    localparam int FIFO_W = AXI_DATA_WIDTH + 1;
    localparam int OCC_W  = $clog2(FIFO_DEPTH) + 1;

    logic                  tready_r;
    logic                  push_s;
    logic                  pop_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [OCC_W-1:0]      fifo_occ_s;
    logic [OCC_W-1:0]      occ_next_s;
    logic [FIFO_W-1:0]     head_s;

    logic                  we_prev_r;
    logic                  wr_fire_s;
    logic                  wr_interval_s;
    logic                  wr_clear_s;

    logic [CNT_WIDTH-1:0]  interval_r;
    logic [CNT_WIDTH-1:0]  beat_cnt_r;
    logic [CNT_WIDTH-1:0]  frame_cnt_r;
    logic [CNT_WIDTH-1:0]  frame_err_cnt_r;
    logic [CNT_WIDTH-1:0]  beat_in_frame_r;
    logic [CNT_WIDTH-1:0]  bif_plus1_s;
    logic [CNT_WIDTH-1:0]  bif_next_s;
    logic                  frame_inc_s;
    logic                  err_inc_s;

    logic [DATA_WIDTH-1:0] rd_mux_s;
    logic [DATA_WIDTH-1:0] ctrl_rdata_r;
    logic                  unused_wdata_hi_s;

    assign unused_wdata_hi_s = ^ctrl_wdata[DATA_WIDTH-1:CNT_WIDTH];

    // tready is a pure register, so out_ready never reaches it combinationally.
    assign push_s        = S_AXIS_tvalid & tready_r & ~fifo_full_s;
    assign pop_s         = out_ready & ~fifo_empty_s;
    assign S_AXIS_tready = tready_r;

    cms_fwft_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .wdata     ({S_AXIS_tlast, S_AXIS_tdata}),
        .pop       (pop_s),
        .rdata     (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .occupancy (fifo_occ_s)
    );

    assign out_valid = ~fifo_empty_s;
    assign out_pc    = head_s[AXI_DATA_WIDTH-1:PC_LSB];
    assign out_instr = head_s[INSTR_LSB+31:INSTR_LSB];
    assign out_last  = head_s[AXI_DATA_WIDTH];

    // Occupancy after this edge, used to precompute next-cycle tready.
    always_comb begin
        occ_next_s = fifo_occ_s;
        case ({push_s, pop_s})
            2'b10:   occ_next_s = fifo_occ_s + OCC_W'(1'b1);
            2'b01:   occ_next_s = fifo_occ_s - OCC_W'(1'b1);
            default: occ_next_s = fifo_occ_s;
        endcase
    end

    // tready register: low in reset, then "not full" for the coming cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tready_r <= 1'b0;
        end else begin
            tready_r <= (occ_next_s != OCC_W'(FIFO_DEPTH));
        end
    end

    // Write strobe qualification: edge-detected or level-sensitive.
    always_comb begin
        wr_fire_s = 1'b0;
        if (CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED != 0) begin
            wr_fire_s = ctrl_write_enable & ~we_prev_r;
        end else begin
            wr_fire_s = ctrl_write_enable;
        end
    end

    assign wr_interval_s = wr_fire_s && (ctrl_addr == CMS_RX_ADDR_INTERVAL);
    assign wr_clear_s    = wr_fire_s && (ctrl_addr == CMS_RX_ADDR_CLEAR);

    // Previous write-enable level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_prev_r <= 1'b0;
        end else begin
            we_prev_r <= ctrl_write_enable;
        end
    end

    // Framing check on each accepted beat; a missing tlast resyncs the count.
    always_comb begin
        frame_inc_s = 1'b0;
        err_inc_s   = 1'b0;
        bif_plus1_s = beat_in_frame_r + 32'd1;
        bif_next_s  = beat_in_frame_r;
        if (push_s) begin
            if (S_AXIS_tlast) begin
                frame_inc_s = 1'b1;
                bif_next_s  = 32'd0;
                if ((interval_r != 32'd0) && (bif_plus1_s != interval_r)) begin
                    err_inc_s = 1'b1;
                end else begin
                    err_inc_s = 1'b0;
                end
            end else if ((interval_r != 32'd0) && (bif_plus1_s == interval_r)) begin
                err_inc_s  = 1'b1;
                bif_next_s = 32'd0;
            end else begin
                bif_next_s = bif_plus1_s;
            end
        end else begin
            bif_next_s = beat_in_frame_r;
        end
    end

    // Interval register and statistics counters; a clear beats any increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            interval_r      <= CNT_WIDTH'(DEFAULT_INTERVAL);
            beat_cnt_r      <= 32'd0;
            frame_cnt_r     <= 32'd0;
            frame_err_cnt_r <= 32'd0;
            beat_in_frame_r <= 32'd0;
        end else begin
            if (wr_interval_s) begin
                interval_r <= ctrl_wdata[CNT_WIDTH-1:0];
            end
            if (wr_clear_s) begin
                beat_cnt_r      <= 32'd0;
                frame_cnt_r     <= 32'd0;
                frame_err_cnt_r <= 32'd0;
                beat_in_frame_r <= 32'd0;
            end else begin
                if (push_s) begin
                    beat_cnt_r <= sat_inc(beat_cnt_r);
                end
                if (frame_inc_s) begin
                    frame_cnt_r <= sat_inc(frame_cnt_r);
                end
                if (err_inc_s) begin
                    frame_err_cnt_r <= sat_inc(frame_err_cnt_r);
                end
                if (wr_interval_s) begin
                    beat_in_frame_r <= 32'd0;
                end else begin
                    beat_in_frame_r <= bif_next_s;
                end
            end
        end
    end

    // Read multiplexer over the register map, zero-extended.
    always_comb begin
        rd_mux_s = {DATA_WIDTH{1'b0}};
        case (ctrl_addr)
            CMS_RX_ADDR_INTERVAL: rd_mux_s = DATA_WIDTH'(interval_r);
            CMS_RX_ADDR_BEATS:    rd_mux_s = DATA_WIDTH'(beat_cnt_r);
            CMS_RX_ADDR_FRAMES:   rd_mux_s = DATA_WIDTH'(frame_cnt_r);
            CMS_RX_ADDR_ERRS:     rd_mux_s = DATA_WIDTH'(frame_err_cnt_r);
            CMS_RX_ADDR_OCC:      rd_mux_s = DATA_WIDTH'(fifo_occ_s);
            default:              rd_mux_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Registered read data, one cycle behind ctrl_addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_rdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            ctrl_rdata_r <= rd_mux_s;
        end
    end

    assign ctrl_rdata = ctrl_rdata_r;

endmodule

// File: tb/tb_cms_stream_receiver.sv
// Directed self-checking bench for cms_stream_receiver.
module tb_cms_stream_receiver;

    logic        clk;
    logic        rst_n;
    logic        S_AXIS_tvalid;
    logic        S_AXIS_tready;
    logic [95:0] S_AXIS_tdata;
    logic        S_AXIS_tlast;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_last;
    logic [7:0]  ctrl_addr;
    logic [63:0] ctrl_wdata;
    logic        ctrl_write_enable;
    logic [63:0] ctrl_rdata;

    int n_assert;
    int n_fail;

    cms_stream_receiver #(
        .XLEN                                (64),
        .AXI_DATA_WIDTH                      (96),
        .FIFO_DEPTH                          (4),
        .DEFAULT_INTERVAL                    (100),
        .CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED (1)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .S_AXIS_tvalid     (S_AXIS_tvalid),
        .S_AXIS_tready     (S_AXIS_tready),
        .S_AXIS_tdata      (S_AXIS_tdata),
        .S_AXIS_tlast      (S_AXIS_tlast),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_instr         (out_instr),
        .out_last          (out_last),
        .ctrl_addr         (ctrl_addr),
        .ctrl_wdata        (ctrl_wdata),
        .ctrl_write_enable (ctrl_write_enable),
        .ctrl_rdata        (ctrl_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic read_reg(input logic [7:0] addr, output logic [63:0] data);
        ctrl_addr = addr;
        @(posedge clk);
        @(negedge clk);
        data = ctrl_rdata;
    endtask

    task automatic write_reg(input logic [7:0] addr, input logic [63:0] data);
        ctrl_addr         = addr;
        ctrl_wdata        = data;
        ctrl_write_enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ctrl_write_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_beat(input logic [63:0] pc, input logic [31:0] instr, input logic last);
        bit acc;
        acc           = 1'b0;
        S_AXIS_tdata  = {pc, instr};
        S_AXIS_tlast  = last;
        S_AXIS_tvalid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (S_AXIS_tready) acc = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tlast  = 1'b0;
        check("push_accepted", {63'd0, acc}, 64'd1);
    endtask

    logic [63:0] rd;

    initial begin
        n_assert          = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        S_AXIS_tvalid     = 1'b0;
        S_AXIS_tdata      = 96'd0;
        S_AXIS_tlast      = 1'b0;
        out_ready         = 1'b0;
        ctrl_addr         = 8'h00;
        ctrl_wdata        = 64'd0;
        ctrl_write_enable = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tready", {63'd0, S_AXIS_tready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_instr", {32'd0, out_instr}, 64'd0);
        check("rst_out_last", {63'd0, out_last}, 64'd0);
        check("rst_rdata", ctrl_rdata, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("tready_after_release", {63'd0, S_AXIS_tready}, 64'd1);
        read_reg(8'h00, rd);
        check("rst_interval", rd, 64'd100);
        read_reg(8'h02, rd);
        check("rst_beats", rd, 64'd0);

        // Streaming with out_ready high: each entry visible one cycle after push
        out_ready = 1'b1;
        push_beat(64'd8, 32'h0000006f, 1'b0);
        check("s1_valid0", {63'd0, out_valid}, 64'd1);
        check("s1_pc0", out_pc, 64'd8);
        check("s1_instr0", {32'd0, out_instr}, 64'h0000006f);
        push_beat(64'd12, 32'h0C601063, 1'b0);
        check("s1_pc1", out_pc, 64'd12);
        check("s1_instr1", {32'd0, out_instr}, 64'h0C601063);
        push_beat(64'd16, 32'h00000067, 1'b0);
        check("s1_pc2", out_pc, 64'd16);
        check("s1_instr2", {32'd0, out_instr}, 64'h00000067);
        @(posedge clk);
        @(negedge clk);
        check("s1_drained", {63'd0, out_valid}, 64'd0);
        read_reg(8'h02, rd);
        check("s1_beats", rd, 64'd3);

        // Backpressure: fill 4 entries, 5th beat held by the source
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_beat(64'h200 + 64'(i * 4), 32'h00000013, 1'b0);
        end
        check("s2_tready_full", {63'd0, S_AXIS_tready}, 64'd0);
        S_AXIS_tdata  = {64'h210, 32'h00000013};
        S_AXIS_tvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("s2_tready_held", {63'd0, S_AXIS_tready}, 64'd0);
        read_reg(8'h05, rd);
        check("s2_occ_full", rd, 64'd4);
        check("s2_head_stable", out_pc, 64'h200);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("s2_tready_after_pop", {63'd0, S_AXIS_tready}, 64'd1);
        check("s2_head_after_pop", out_pc, 64'h204);
        @(posedge clk);
        @(negedge clk);
        S_AXIS_tvalid = 1'b0;
        check("s2_tready_refull", {63'd0, S_AXIS_tready}, 64'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("s2_drain_valid", {63'd0, out_valid}, 64'd1);
            check("s2_drain_pc", out_pc, 64'h200 + 64'(i * 4));
            @(posedge clk);
            @(negedge clk);
        end
        check("s2_empty", {63'd0, out_valid}, 64'd0);
        read_reg(8'h02, rd);
        check("s2_beats", rd, 64'd8);

        // Framing at interval 100
        write_reg(8'h01, 64'd0);
        for (int i = 1; i <= 200; i++) begin
            push_beat(64'h1000 + 64'(i * 4), 32'h00000013, ((i % 100) == 0));
        end
        read_reg(8'h03, rd);
        check("s3_frames", rd, 64'd2);
        read_reg(8'h04, rd);
        check("s3_errs", rd, 64'd0);
        read_reg(8'h02, rd);
        check("s3_beats", rd, 64'd200);
        write_reg(8'h00, 64'd4);
        read_reg(8'h00, rd);
        check("s3_interval4", rd, 64'd4);
        push_beat(64'h2000, 32'h00000013, 1'b0);
        push_beat(64'h2004, 32'h00000013, 1'b0);
        push_beat(64'h2008, 32'h00000013, 1'b1);
        check("s3_out_last", {63'd0, out_last}, 64'd1);
        read_reg(8'h04, rd);
        check("s3_short_frame_err", rd, 64'd1);
        read_reg(8'h03, rd);
        check("s3_frames3", rd, 64'd3);

        // Missing tlast at interval 4: two errors, then resync
        write_reg(8'h01, 64'd0);
        for (int i = 0; i < 8; i++) begin
            push_beat(64'h3000 + 64'(i * 4), 32'h00000013, 1'b0);
        end
        read_reg(8'h04, rd);
        check("s4_missing_tlast_errs", rd, 64'd2);
        read_reg(8'h03, rd);
        check("s4_frames0", rd, 64'd0);
        for (int i = 0; i < 4; i++) begin
            push_beat(64'h3100 + 64'(i * 4), 32'h00000013, (i == 3));
        end
        read_reg(8'h04, rd);
        check("s4_resync_no_err", rd, 64'd2);
        read_reg(8'h03, rd);
        check("s4_resync_frame", rd, 64'd1);
        // Clear coinciding with an accepted beat
        S_AXIS_tdata      = {64'h3200, 32'h00000013};
        S_AXIS_tlast      = 1'b1;
        S_AXIS_tvalid     = 1'b1;
        ctrl_addr         = 8'h01;
        ctrl_write_enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        S_AXIS_tvalid     = 1'b0;
        S_AXIS_tlast      = 1'b0;
        ctrl_write_enable = 1'b0;
        read_reg(8'h02, rd);
        check("s4_clear_beats", rd, 64'd0);
        read_reg(8'h03, rd);
        check("s4_clear_frames", rd, 64'd0);
        read_reg(8'h04, rd);
        check("s4_clear_errs", rd, 64'd0);

        // Edge-triggered write: held enable only acts once
        ctrl_addr         = 8'h00;
        ctrl_wdata        = 64'd7;
        ctrl_write_enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ctrl_wdata = 64'd9;
        repeat (4) @(negedge clk);
        ctrl_write_enable = 1'b0;
        read_reg(8'h00, rd);
        check("s5_posedge_interval", rd, 64'd7);
        write_reg(8'h07, 64'd55);
        read_reg(8'h07, rd);
        check("s5_unmapped_read", rd, 64'd0);
        read_reg(8'h00, rd);
        check("s5_unmapped_write_ignored", rd, 64'd7);

        // Reset with beats buffered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_beat(64'h4000 + 64'(i * 4), 32'h00000013, 1'b0);
        end
        read_reg(8'h05, rd);
        check("s6_occ3", rd, 64'd3);
        rst_n = 1'b0;
        #1;
        check("s6_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("s6_rst_tready", {63'd0, S_AXIS_tready}, 64'd0);
        check("s6_rst_rdata", ctrl_rdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("s6_tready", {63'd0, S_AXIS_tready}, 64'd1);
        check("s6_out_valid", {63'd0, out_valid}, 64'd0);
        read_reg(8'h02, rd);
        check("s6_beats", rd, 64'd0);
        read_reg(8'h00, rd);
        check("s6_interval", rd, 64'd100);
        read_reg(8'h05, rd);
        check("s6_occ", rd, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
